wr_ptr_ctrl: RTL and testbench
==============================

Name: wr_ptr_ctrl

Overview:
- Write-side pointer controller for the async FIFO, in the write clock domain.
- Owns the binary write pointer and the registered Gray-coded write pointer exported to the read domain.
- Synchronises the incoming Gray read pointer and derives full, almost_full, the fill level and a sticky overflow flag.
- Gates memory write strobes so the FIFO RAM is never written when full.

Parameters:
ADDR_W, 4, RAM address width; depth = 2^ADDR_W; pointers are ADDR_W+1 bits
SYNC_STAGES, 2, flop stages on the read-pointer crossing (minimum 2)
AF_MARGIN, 2, almost_full asserts when free slots <= AF_MARGIN

Ports:
clk  in  1  write-domain clock
rst  in  1  asynchronous, active-high reset
wr_en  in  1  write request from producer
rptr_gray_async  in  ADDR_W+1  Gray read pointer from the read domain (unsynchronised)
wr_accept  out  1  RAM write strobe = wr_en & ~full (combinational)
waddr  out  ADDR_W  RAM write address = wbin[ADDR_W-1:0]
wptr_gray  out  ADDR_W+1  registered Gray write pointer, to read domain
full  out  1  registered full flag
almost_full  out  1  wr_count >= 2^ADDR_W - AF_MARGIN
wr_count  out  ADDR_W+1  fill level as seen from the write domain
overflow  out  1  sticky: write attempted while full

Behaviour:
- Reset (async assert, release on clk): wbin=0, wptr_gray=0, all sync flops=0, full=0, overflow=0. Therefore waddr=0, wr_count=0, almost_full=0 and wr_accept=0 during reset.
- Pointer advance: on a rising edge with wr_accept=1, wbin <= wbin+1, modulo 2^(ADDR_W+1).
  - wptr_gray <= wbin_next ^ (wbin_next >> 1), registered with no combinational path to the output.
  - wptr_gray changes exactly one bit per accept.
- Without wr_accept, wbin and wptr_gray hold.
- Synchroniser: rptr_gray_async passes through SYNC_STAGES flops; rq_sync is the last stage. No logic sits between stages.
- Read-pointer decode: rbin_sync = Gray-to-binary of rq_sync, using prefix XOR from the MSB: b[n] = g[n], b[i] = b[i+1] ^ g[i].
- Full:
  - full <= (wgray_next == {~rq_sync[ADDR_W:ADDR_W-1], rq_sync[ADDR_W-2:0]}), where wgray_next is the Gray value of the post-increment pointer (or the current pointer if no accept).
  - full asserts on the same edge that accepts the last free slot.
  - full deasserts on the (SYNC_STAGES+1)th edge after a read-pointer change is stable at the input.
- wr_count = wbin - rbin_sync, modulo 2^(ADDR_W+1); combinational from registers; range 0..2^ADDR_W.
- almost_full: combinational from wr_count.
- Overflow: overflow <= 1 on any edge with wr_en=1 and full=1. It clears only on rst.
  - A rejected write does not move the pointer or strobe the RAM.
- Wrap-around:
  - waddr wraps 2^ADDR_W-1 -> 0.
  - The extra pointer MSB toggles and provides the wrap distinction between full and empty.
  - wbin wraps 2^(ADDR_W+1)-1 -> 0; Gray wraps from {1,0...0} to 0.
- Simultaneous write on the last slot and read-pointer update: full is computed from the current rq_sync. It may assert for up to SYNC_STAGES+1 cycles pessimistically, and must never be late.
- Reset mid-operation: immediate async clear of all state. The producer must discard in-flight data.
- rptr_gray_async is required to change by at most one bit per read-domain edge; this block does not check it.

Test Plan:
1. Reset, then 16 writes with rptr_gray_async=0 -> waddr 0..15; full=1 after 16th accept; wptr_gray=5'b11000; wr_count=16; waddr=0.
2. From full, wr_en=1 for 3 cycles -> wr_accept=0, pointers unchanged, overflow=1 and stays 1 after wr_en drops.
3. From full, set rptr_gray_async=5'b00001 -> full clears on 3rd edge (SYNC_STAGES=2); wr_count=15; the next write is accepted at waddr=0.
4. Fill level 13 then 14 -> almost_full=0 at 13, 1 at 14; 1 at 16; back to 0 when a read brings the count to 13.
5. Stream 40 writes with rptr tracking 2 behind -> wbin wraps 31->0 with wptr_gray 5'b10000->5'b00000; full never asserts; every wptr_gray step differs in exactly one bit.
6. Assert rst mid-stream, asynchronously between edges -> all outputs clear before the next edge; after release, the first write is at waddr=0 with wptr_gray=5'b00001.

Source files
------------

// File: rtl/wr_ptr_ctrl.sv
// ---------------------------------------------------------------------------
// wr_ptr_ctrl
//
// Write-side pointer controller of an asynchronous FIFO, living entirely in
// the write clock domain. It owns the binary write pointer, exports a
// registered Gray copy of it to the read domain, brings the read domain's
// Gray pointer across a flop synchroniser, and from the two derives the
// full / almost_full flags, the fill level and a sticky overflow flag. The
// RAM write strobe is gated so the FIFO memory is never written while full.
//
// Parameters
//   ADDR_W      RAM address width; depth is 2**ADDR_W, pointers are ADDR_W+1
//   SYNC_STAGES flop stages on the read-pointer crossing (2 or more)
//   AF_MARGIN   almost_full asserts when free slots <= AF_MARGIN
//
// Ports
//   clk              write-domain clock
//   rst              asynchronous, active-high reset
//   wr_en            write request from the producer
//   rptr_gray_async  Gray read pointer straight from the read domain
//   wr_accept        RAM write strobe (wr_en while not full)
//   waddr            RAM write address (low bits of the binary pointer)
//   wptr_gray        registered Gray write pointer, to the read domain
//   full             registered full flag
//   almost_full      fill level has reached 2**ADDR_W - AF_MARGIN
//   wr_count         fill level as seen from the write domain
//   overflow         sticky: a write was attempted while full
// ---------------------------------------------------------------------------
module wr_ptr_ctrl #(
  parameter int ADDR_W      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int AF_MARGIN   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W:0]   rptr_gray_async,
  output logic              wr_accept,
  output logic [ADDR_W-1:0] waddr,
  output logic [ADDR_W:0]   wptr_gray,
  output logic              full,
  output logic              almost_full,
  output logic [ADDR_W:0]   wr_count,
  output logic              overflow
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] AF_LEVEL = (ADDR_W+1)'(DEPTH - AF_MARGIN);

  logic [ADDR_W:0] wbin_q;
  logic [ADDR_W:0] wbin_d;
  logic [ADDR_W:0] wgray_q;
  logic [ADDR_W:0] wgray_d;
  logic            full_q;
  logic            full_d;
  logic            overflow_q;
  logic            overflow_d;
  logic [ADDR_W:0] sync_q [SYNC_STAGES];
  logic [ADDR_W:0] rq_sync;
  logic [ADDR_W:0] rbin_sync;
  logic [ADDR_W:0] full_pattern;

  // The strobe is also held low while reset is asserted so that a producer
  // still driving wr_en during reset never writes the RAM.
  assign wr_accept = wr_en & ~full_q & ~rst;

  // Next pointer values; the Gray form is computed from the post-increment
  // binary so the exported pointer is a plain register with no logic after it.
  assign wbin_d  = wbin_q + (ADDR_W+1)'(wr_accept);
  assign wgray_d = wbin_d ^ (wbin_d >> 1);

  // Last synchroniser stage is the only copy of the read pointer used here.
  assign rq_sync = sync_q[SYNC_STAGES-1];

  // Gray-to-binary by prefix XOR from the MSB down.
  always_comb begin
    rbin_sync         = '0;
    rbin_sync[ADDR_W] = rq_sync[ADDR_W];
    for (int i = ADDR_W - 1; i >= 0; i--) begin
      rbin_sync[i] = rbin_sync[i+1] ^ rq_sync[i];
    end
  end

  // In Gray space "write is exactly one lap ahead of read" means the top two
  // bits are inverted and the rest are equal. Comparing against the next
  // write pointer lets full rise on the same edge that takes the last slot.
  assign full_pattern = {~rq_sync[ADDR_W:ADDR_W-1], rq_sync[ADDR_W-2:0]};
  assign full_d       = (wgray_d == full_pattern);

  assign overflow_d = overflow_q | (wr_en & full_q);

  // Pointer, flag and overflow registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wbin_q     <= '0;
      wgray_q    <= '0;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wbin_q     <= wbin_d;
      wgray_q    <= wgray_d;
      full_q     <= full_d;
      overflow_q <= overflow_d;
    end
  end

  // Plain flop chain for the read-pointer crossing; nothing may sit between
  // stages or the metastability settling time is lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= rptr_gray_async;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  // Modulo subtraction gives the fill level directly because both pointers
  // carry the extra wrap bit.
  assign wr_count    = wbin_q - rbin_sync;
  assign almost_full = (wr_count >= AF_LEVEL);

  assign waddr     = wbin_q[ADDR_W-1:0];
  assign wptr_gray = wgray_q;
  assign full      = full_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_wr_ptr_ctrl.sv
// ---------------------------------------------------------------------------
// tb_wr_ptr_ctrl
//
// Directed plus randomised bench for wr_ptr_ctrl. The reference keeps the
// number of writes accepted and the read position as plain integers; the
// read pointer reaching the write domain is a delay line of past read
// positions, and full / fill level come from integer differences.
// ---------------------------------------------------------------------------
module tb_wr_ptr_ctrl;

  localparam int ADDR_W      = 4;
  localparam int SYNC_STAGES = 2;
  localparam int AF_MARGIN   = 2;
  localparam int DEPTH       = 1 << ADDR_W;
  localparam int PMASK       = (2 * DEPTH) - 1;

  logic              clk;
  logic              rst;
  logic              wr_en;
  logic [ADDR_W:0]   rptr_gray_async;
  logic              wr_accept;
  logic [ADDR_W-1:0] waddr;
  logic [ADDR_W:0]   wptr_gray;
  logic              full;
  logic              almost_full;
  logic [ADDR_W:0]   wr_count;
  logic              overflow;

  wr_ptr_ctrl #(
    .ADDR_W      (ADDR_W),
    .SYNC_STAGES (SYNC_STAGES),
    .AF_MARGIN   (AF_MARGIN)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .wr_en           (wr_en),
    .rptr_gray_async (rptr_gray_async),
    .wr_accept       (wr_accept),
    .waddr           (waddr),
    .wptr_gray       (wptr_gray),
    .full            (full),
    .almost_full     (almost_full),
    .wr_count        (wr_count),
    .overflow        (overflow)
  );

  // Free-running write clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int miscompares;

  // Reference state
  int wTot;
  int rTot;
  int syncQ[$];
  bit modelFull;
  bit modelOvf;
  bit lastAccept;
  logic [ADDR_W:0] lastGrayObs;
  bit fullSeen;

  function automatic logic [ADDR_W:0] toGray(input int v);
    logic [ADDR_W:0] b;
    b = (ADDR_W+1)'(v & PMASK);
    return b ^ (b >> 1);
  endfunction

  function automatic int fillLevel();
    return (wTot - syncQ[0]) & PMASK;
  endfunction

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Full comparison of every registered/derived output against the model.
  task automatic checkOutput();
    int lvl;
    lvl = fillLevel();
    checkValue("waddr",       32'(waddr),       32'(wTot % DEPTH));
    checkValue("wptr_gray",   32'(wptr_gray),   32'(toGray(wTot)));
    checkValue("full",        32'(full),        32'(modelFull));
    checkValue("wr_count",    32'(wr_count),    32'(lvl));
    checkValue("almost_full", 32'(almost_full), 32'(lvl >= DEPTH - AF_MARGIN));
    checkValue("overflow",    32'(overflow),    32'(modelOvf));
    checkValue("gray_step",   32'($countones(wptr_gray ^ lastGrayObs)), 32'(lastAccept));
    lastGrayObs = wptr_gray;
    fullSeen    = fullSeen | full;
  endtask

  task automatic modelReset();
    wTot       = 0;
    rTot       = 0;
    modelFull  = 1'b0;
    modelOvf   = 1'b0;
    lastAccept = 1'b0;
    lastGrayObs = '0;
    syncQ.delete();
    for (int i = 0; i < SYNC_STAGES; i++) syncQ.push_back(0);
  endtask

  // One clock cycle: drive inputs after the falling edge, check the
  // combinational strobe before the rising edge, advance the model on the
  // edge and check every output 1 time unit later.
  task automatic applyStimulus(input bit wrEn, input int rdTarget);
    bit acc;
    int rqOld;
    @(negedge clk);
    rTot            = rdTarget;
    wr_en           = wrEn;
    rptr_gray_async = toGray(rTot);
    #1;
    acc = wrEn && !modelFull;
    checkValue("wr_accept", 32'(wr_accept), 32'(acc));
    checkValue("waddr_pre", 32'(waddr),     32'(wTot % DEPTH));
    @(posedge clk);
    if (wrEn && modelFull) modelOvf = 1'b1;
    if (acc) wTot++;
    rqOld     = syncQ[0];
    modelFull = (((wTot - rqOld) & PMASK) == DEPTH);
    void'(syncQ.pop_front());
    syncQ.push_back(rTot);
    lastAccept = acc;
    #1;
    checkOutput();
  endtask

  task automatic doReset();
    @(negedge clk);
    rst             = 1'b1;
    wr_en           = 1'b1;
    rptr_gray_async = '0;
    modelReset();
    #1;
    checkValue("rst_accept", 32'(wr_accept), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput();
    @(negedge clk);
    wr_en = 1'b0;
    rst   = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    fullSeen    = 1'b0;
    rst         = 1'b0;
    wr_en       = 1'b0;
    rptr_gray_async = '0;
    modelReset();

    // 1: fill all 16 slots with the reader parked at 0
    doReset();
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 0);
    checkValue("t1_full",  32'(full),      32'd1);
    checkValue("t1_gray",  32'(wptr_gray), 32'b11000);
    checkValue("t1_count", 32'(wr_count),  32'd16);
    checkValue("t1_waddr", 32'(waddr),     32'd0);

    // 2: writes against a full FIFO are rejected and flag overflow
    repeat (3) applyStimulus(1'b1, 0);
    applyStimulus(1'b0, 0);
    checkValue("t2_ovf",  32'(overflow),  32'd1);
    checkValue("t2_gray", 32'(wptr_gray), 32'b11000);

    // 3: one read; full clears on the third edge after the change
    applyStimulus(1'b0, 1);
    applyStimulus(1'b0, 1);
    checkValue("t3_full_held", 32'(full), 32'd1);
    applyStimulus(1'b0, 1);
    checkValue("t3_full_clr", 32'(full),     32'd0);
    checkValue("t3_count",    32'(wr_count), 32'd15);
    applyStimulus(1'b1, 1);
    checkValue("t3_wrap_waddr", 32'(waddr), 32'd1);

    // 4: almost_full thresholds
    applyStimulus(1'b0, 2);
    applyStimulus(1'b0, 3);
    applyStimulus(1'b0, 4);
    repeat (3) applyStimulus(1'b0, 4);
    checkValue("t4_count13", 32'(wr_count),    32'd13);
    checkValue("t4_af13",    32'(almost_full), 32'd0);
    applyStimulus(1'b1, 4);
    checkValue("t4_af14", 32'(almost_full), 32'd1);
    applyStimulus(1'b1, 4);
    applyStimulus(1'b1, 4);
    checkValue("t4_af16",   32'(almost_full), 32'd1);
    checkValue("t4_full16", 32'(full),        32'd1);
    applyStimulus(1'b0, 5);
    applyStimulus(1'b0, 6);
    applyStimulus(1'b0, 7);
    repeat (3) applyStimulus(1'b0, 7);
    checkValue("t4_af_back", 32'(almost_full), 32'd0);

    // 5: stream 40 writes with the reader two behind, crossing the wrap
    doReset();
    fullSeen = 1'b0;
    for (int i = 0; i < 40; i++) applyStimulus(1'b1, (wTot >= 2) ? wTot - 2 : 0);
    checkValue("t5_no_full", 32'(fullSeen),  32'd0);
    checkValue("t5_gray40",  32'(wptr_gray), 32'b01100);

    // 6: asynchronous reset between edges
    repeat (5) applyStimulus(1'b1, rTot);
    #2;
    rst = 1'b1;
    modelReset();
    #1;
    checkOutput();
    checkValue("t6_accept", 32'(wr_accept), 32'd0);
    @(negedge clk);
    wr_en = 1'b0;
    rptr_gray_async = '0;
    rst = 1'b0;
    applyStimulus(1'b1, 0);
    checkValue("t6_gray", 32'(wptr_gray), 32'b00001);

    // Randomised traffic: biased writer, reader advancing one step at a time
    for (int i = 0; i < 400; i++) begin
      bit we;
      int rd;
      we = ($urandom_range(0, 3) != 0);
      rd = rTot;
      if (($urandom_range(0, 2) == 0) && (rd < wTot)) rd++;
      applyStimulus(we, rd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
